// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes and FSM states.
package hilo_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used both to take |operand| and to restore result signs.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? -val : val;

endmodule

// File: rtl/hilo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit: radix-2 shift-add and restoring divide sharing one
// 2W accumulator; results are sign-fixed and registered into hi/lo on the FIX step.
module hilo_muldiv
    import hilo_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               zero_q, zero_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;

    logic               div_op, sgn_op;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign div_op = (md_op_e'(op) == MD_DIV) || (md_op_e'(op) == MD_DIVU);
    assign sgn_op = (md_op_e'(op) == MD_MULT) || (md_op_e'(op) == MD_DIV);

    muldiv_sign_fix #(.W(WIDTH)) u_abs_a (
        .val(a), .neg(sgn_op & a[WIDTH-1]), .res(abs_a)
    );
    muldiv_sign_fix #(.W(WIDTH)) u_abs_b (
        .val(b), .neg(sgn_op & b[WIDTH-1]), .res(abs_b)
    );
    muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
        .val(acc_q), .neg(neg_res_q), .res(prod_fix)
    );
    muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (
        .val(acc_q[WIDTH-1:0]), .neg(neg_res_q), .res(quo_fix)
    );
    muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
        .val(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_rem_q), .res(rem_fix)
    );

    // Multiply step: multiplier sits in the low half and shifts out as the product shifts in.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_mul;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    assign acc_mul = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: partial remainder in the high half, quotient bits fill the low half.
    logic [WIDTH:0]     div_trial, div_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] acc_div;
    assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, opb_q};
    assign q_bit     = (div_trial >= {1'b0, opb_q});
    assign div_rem   = q_bit ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
    assign acc_div   = {div_rem, acc_q[WIDTH-2:0], q_bit};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        zero_d    = zero_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                    div_d   = div_op;
                    zero_d  = div_op && (b == '0);
                    if (div_op && (b == '0)) begin
                        // Dividing the raw a by 0 leaves a as remainder and all-ones quotient.
                        acc_d     = {{WIDTH{1'b0}}, a};
                        opb_d     = '0;
                        neg_res_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end else if (div_op) begin
                        acc_d     = {{WIDTH{1'b0}}, abs_a};
                        opb_d     = abs_b;
                        neg_res_d = sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = sgn_op & a[WIDTH-1];
                    end else begin
                        acc_d     = {{WIDTH{1'b0}}, abs_b};
                        opb_d     = abs_a;
                        neg_res_d = sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = 1'b0;
                    end
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = div_q ? acc_div : acc_mul;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                    dz_d    = zero_q;
                    if (div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            zero_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            zero_q    <= zero_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            dz_q      <= dz_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE) && !cancel;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

endmodule
